// File: rtl/write_back_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : write_back_arbiter
// Purpose  : Fixed-priority write-back port arbiter with bounded starvation of
//            the multi-cycle unit; registered register-file write port.
// Revision : 1.0
// ============================================================================
module write_back_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid0,
    input  logic [ADDR_WIDTH-1:0] rd0,
    input  logic [BUS_WIDTH-1:0]  data0,
    output logic                  ready0,
    input  logic                  flush0,
    input  logic                  valid1,
    input  logic [ADDR_WIDTH-1:0] rd1,
    input  logic [BUS_WIDTH-1:0]  data1,
    output logic                  ready1,
    output logic                  wb_select,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [BUS_WIDTH-1:0]  rf_wr_data
);

    localparam int                 c_cnt_width = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_width-1:0] c_limit = c_cnt_width'(STARVE_LIMIT);

    logic [c_cnt_width-1:0] r_starve_cnt;
    logic                   r_wb_select;
    logic                   r_rf_wr_en;
    logic [ADDR_WIDTH-1:0]  r_rf_wr_addr;
    logic [BUS_WIDTH-1:0]   r_rf_wr_data;

    logic                   w_force1;
    logic                   w_v0;
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_any_grant;
    logic [ADDR_WIDTH-1:0]  w_sel_rd;
    logic [BUS_WIDTH-1:0]   w_sel_data;
    logic [c_cnt_width-1:0] w_starve_cnt_nxt;

    // FORCED state is simply the saturated counter; it returns to NORMAL
    // once the forced grant clears the counter.
    assign w_force1    = (r_starve_cnt == c_limit);
    assign w_v0        = valid0 & ~flush0;
    assign w_grant1    = valid1 & (~w_v0 | w_force1);
    assign w_grant0    = w_v0 & ~w_grant1;
    assign w_any_grant = w_grant0 | w_grant1;

    // A flushed requester-0 entry is consumed without producing a write.
    assign ready0 = rst_n & (w_grant0 | (valid0 & flush0));
    assign ready1 = rst_n & w_grant1;

    assign w_sel_rd   = w_grant1 ? rd1   : rd0;
    assign w_sel_data = w_grant1 ? data1 : data0;

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_grant1 || !valid1) begin
            w_starve_cnt_nxt = '0;
        end else if (r_starve_cnt < c_limit) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_wb_select  <= 1'b0;
            r_rf_wr_en   <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wr_data <= '0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rf_wr_en   <= w_any_grant & (w_sel_rd != '0);
            if (w_any_grant) begin
                r_wb_select  <= w_grant1;
                r_rf_wr_addr <= w_sel_rd;
                r_rf_wr_data <= w_sel_data;
            end
        end
    end

    assign wb_select  = r_wb_select;
    assign rf_wr_en   = r_rf_wr_en;
    assign rf_wr_addr = r_rf_wr_addr;
    assign rf_wr_data = r_rf_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_write_back_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_back_arbiter
// Purpose  : Directed and randomized checks of write_back_arbiter.
// Revision : 1.0
// ============================================================================
module tb_write_back_arbiter;

    localparam int BW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid0 = 1'b0, flush0 = 1'b0, valid1 = 1'b0;
    logic [AW-1:0] rd0 = '0, rd1 = '0;
    logic [BW-1:0] data0 = '0, data1 = '0;
    logic          ready0, ready1, wb_select, rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [BW-1:0] rf_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: lost-cycle count plus the expected write-port contents.
    int            m_cnt;
    logic          m_sel, m_en;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_data;

    write_back_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid0(valid0), .rd0(rd0), .data0(data0), .ready0(ready0), .flush0(flush0),
        .valid1(valid1), .rd1(rd1), .data1(data1), .ready1(ready1),
        .wb_select(wb_select), .rf_wr_en(rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cnt = 0; m_sel = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endfunction

    // Requester 1 wins if requester 0 has nothing live, or it has lost LIM times.
    function automatic logic exp_g1();
        return valid1 && (!(valid0 && !flush0) || m_cnt >= LIM);
    endfunction

    function automatic logic exp_g0();
        return valid0 && !flush0 && !exp_g1();
    endfunction

    function automatic void model_edge();
        logic g0, g1;
        g1 = exp_g1();
        g0 = exp_g0();
        if (g1 || !valid1) m_cnt = 0;
        else if (m_cnt < LIM) m_cnt = m_cnt + 1;
        if (g0 || g1) begin
            m_sel  = g1;
            m_addr = g1 ? rd1 : rd0;
            m_data = g1 ? data1 : data0;
            m_en   = (m_addr != 0);
        end else begin
            m_en = 1'b0;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid0 = 1'b0; flush0 = 1'b0; valid1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid0 = 1'b1; rd0 = 5'd4; data0 = 32'h55;
        model_reset();
        @(negedge clk); @(negedge clk);
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", rf_wr_en); end
        n_cmp++; if (wb_select !== 1'b0) begin n_err++; $display("FAIL reset_sel got=%b exp=0", wb_select); end
        n_cmp++; if (rf_wr_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%0h exp=0", rf_wr_addr); end
        n_cmp++; if (rf_wr_data !== '0) begin n_err++; $display("FAIL reset_data got=%0h exp=0", rf_wr_data); end
        n_cmp++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b%b exp=00", ready0, ready1); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        valid0 = 1'b1; rd0 = 5'd5; data0 = 32'hDEADBEEF;
        #1;
        n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL single_ready0 got=%b exp=1", ready0); end
        tick();
        idle_inputs();
        n_cmp++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL single_en got=%b exp=1", rf_wr_en); end
        n_cmp++; if (rf_wr_addr !== 5'd5) begin n_err++; $display("FAIL single_addr got=%0d exp=5", rf_wr_addr); end
        n_cmp++; if (rf_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got=%h exp=deadbeef", rf_wr_data); end
        n_cmp++; if (wb_select !== 1'b0) begin n_err++; $display("FAIL single_sel got=%b exp=0", wb_select); end
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] pattern = 10'b1000010000;  // bit i = expected grant in cycle i
        logic       prev_g1 = 1'b0;
        valid0 = 1'b1; rd0 = 5'd10; data0 = 32'hA0A0A0A0;
        valid1 = 1'b1; rd1 = 5'd11; data1 = 32'hB1B1B1B1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (ready1 !== pattern[i]) begin n_err++; $display("FAIL starve_grant%0d got=%b exp=%b", i, ready1, pattern[i]); end
            if (i > 0) begin
                n_cmp++; if (wb_select !== prev_g1) begin n_err++; $display("FAIL starve_sel%0d got=%b exp=%b", i, wb_select, prev_g1); end
            end
            prev_g1 = pattern[i];
            tick();
        end
        n_cmp++; if (wb_select !== 1'b1) begin n_err++; $display("FAIL starve_sel_last got=%b exp=1", wb_select); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        valid0 = 1'b1; flush0 = 1'b1; rd0 = 5'd2; data0 = 32'h1111;
        valid1 = 1'b1; rd1 = 5'd7; data1 = 32'h12345678;
        #1;
        n_cmp++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b%b exp=11", ready0, ready1); end
        tick();
        idle_inputs();
        n_cmp++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL flush_en got=%b exp=1", rf_wr_en); end
        n_cmp++; if (rf_wr_addr !== 5'd7) begin n_err++; $display("FAIL flush_addr got=%0d exp=7", rf_wr_addr); end
        n_cmp++; if (rf_wr_data !== 32'h12345678) begin n_err++; $display("FAIL flush_data got=%h exp=12345678", rf_wr_data); end
        n_cmp++; if (wb_select !== 1'b1) begin n_err++; $display("FAIL flush_sel got=%b exp=1", wb_select); end
        tick();
    endtask

    task automatic test_x0();
        // Lose once first so the counter is non-zero before the x0 grant.
        valid0 = 1'b1; rd0 = 5'd6; data0 = 32'h66;
        valid1 = 1'b1; rd1 = 5'd0; data1 = 32'hFFFFFFFF;
        tick();
        valid0 = 1'b0;
        #1;
        n_cmp++; if (ready1 !== 1'b1) begin n_err++; $display("FAIL x0_ready1 got=%b exp=1", ready1); end
        tick();
        idle_inputs();
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_en got=%b exp=0", rf_wr_en); end
        n_cmp++; if (dut.r_starve_cnt !== '0) begin n_err++; $display("FAIL x0_cnt got=%0d exp=0", dut.r_starve_cnt); end
        tick();
    endtask

    task automatic test_idle_hold();
        valid0 = 1'b1; rd0 = 5'd3; data0 = 32'h33333333;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL idle_en%0d got=%b exp=0", i, rf_wr_en); end
            n_cmp++; if (rf_wr_addr !== 5'd3) begin n_err++; $display("FAIL idle_addr%0d got=%0d exp=3", i, rf_wr_addr); end
            n_cmp++; if (wb_select !== 1'b0) begin n_err++; $display("FAIL idle_sel%0d got=%b exp=0", i, wb_select); end
        end
    endtask

    task automatic test_reset_mid();
        valid0 = 1'b1; rd0 = 5'd9; data0 = 32'h99999999;
        tick();
        n_cmp++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL midrst_pre_en got=%b exp=1", rf_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_en got=%b exp=0", rf_wr_en); end
        n_cmp++; if (rf_wr_addr !== '0 || rf_wr_data !== '0 || wb_select !== 1'b0) begin
            n_err++; $display("FAIL midrst_regs got=%0h/%0h/%b exp=0/0/0", rf_wr_addr, rf_wr_data, wb_select); end
        n_cmp++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin n_err++; $display("FAIL midrst_ready got=%b%b exp=00", ready0, ready1); end
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic g1;
        for (int i = 0; i < 300; i++) begin
            valid0 = ($urandom_range(0, 9) < 7);
            flush0 = ($urandom_range(0, 9) < 2);
            rd0    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            data0  = $urandom;
            if (!valid1 && $urandom_range(0, 9) < 5) begin
                valid1 = 1'b1;
                rd1    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                data1  = $urandom;
            end
            #1;
            g1 = exp_g1();
            n_cmp++; if (ready0 !== (exp_g0() | (valid0 & flush0))) begin n_err++; $display("FAIL rand_ready0 it=%0d got=%b exp=%b", i, ready0, exp_g0() | (valid0 & flush0)); end
            n_cmp++; if (ready1 !== g1) begin n_err++; $display("FAIL rand_ready1 it=%0d got=%b exp=%b", i, ready1, g1); end
            tick();
            n_cmp++; if (rf_wr_en !== m_en) begin n_err++; $display("FAIL rand_en it=%0d got=%b exp=%b", i, rf_wr_en, m_en); end
            n_cmp++; if (wb_select !== m_sel) begin n_err++; $display("FAIL rand_sel it=%0d got=%b exp=%b", i, wb_select, m_sel); end
            n_cmp++; if (rf_wr_addr !== m_addr) begin n_err++; $display("FAIL rand_addr it=%0d got=%0d exp=%0d", i, rf_wr_addr, m_addr); end
            n_cmp++; if (rf_wr_data !== m_data) begin n_err++; $display("FAIL rand_data it=%0d got=%h exp=%h", i, rf_wr_data, m_data); end
            if (g1) valid1 = 1'b0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_starvation();
        test_flush();
        test_x0();
        test_idle_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
